mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Shares one 2:1 data mux between two requesters (A, B) with valid/ready handshakes.
//  Round-robin arbitration drives the mux select; the selected beat goes into a one-deep output register.
//  Sits in front of any single-consumer sink that previously took a hard-wired mux select.
// PARAMETERS
//  DW      8   data width of each requester and of the output
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  a_valid     in   1   requester A has a beat
//  a_data      in   DW  requester A data
//  a_last      in   1   A beat ends a burst (used only with ARB_LOCK_EN)
//  a_ready     out  1   A beat accepted this cycle when a_valid & a_ready
//  b_valid/b_data/b_last/b_ready   same as A, for requester B
//  out_valid   out  1   output register holds a beat
//  out_data    out  DW  registered mux output
//  out_sel     out  1   source of held beat: 0=A, 1=B (mux select, registered)
//  out_ready   in   1   sink accepts beat when out_valid & out_ready
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, last_grant=1 (B), state=IDLE.
//  can_load = !out_valid | out_ready (output empty or draining this cycle).
//  Grant (combinational), by state:
//   IDLE: only one valid -> grant it; both valid -> grant !last_grant; none -> no grant.
//   LOCK_A / LOCK_B: grant A / B only; the other requester is ignored even when valid.
//  a_ready = grant==A & can_load; b_ready = grant==B & can_load. Never both 1.
//  On accepted beat: out_data<=granted data, out_sel<=grant, out_valid<=1, last_grant<=grant.
//  Latency: accept at edge N -> out_valid=1 at N+1. Throughput 1 beat/cycle while out_ready=1.
//  out_ready=1 with no accept -> out_valid<=0. out_valid stays 1 and out_data/out_sel stay stable while out_ready=0.
//  Fairness: with both requesters continuously valid and out_ready=1, grants alternate A,B,A,B...
//   In IDLE the first contested grant goes to A.
//  Requester dropping valid before it is accepted is legal; it simply loses the grant.
//  Reset mid-transfer: the held beat is discarded, state -> IDLE, and the lock is released.
//  State machine: IDLE, LOCK_A, LOCK_B (2-bit encoding from package).
// CONFIGURATION
//  ARB_LOCK_EN defined:
//   An accepted beat from X with X_last=0 moves to LOCK_X.
//   An accepted beat from X with X_last=1 returns to IDLE.
//   IDLE accept with X_last=1 stays in IDLE.
//   Bursts are never interleaved.
//  ARB_LOCK_EN undefined:
//   a_last and b_last are ignored; state is always IDLE and arbitration is per beat.
//   LOCK_A/LOCK_B are unreachable, and the lock logic is not compiled.
// STRUCTURE
//  Package mux2_arb_pkg:
//   state encoding ST_IDLE=2'd0, ST_LOCK_A=2'd1, ST_LOCK_B=2'd2.
//   select constants SEL_A=1'b0, SEL_B=1'b1.
//  Sub-module mux2_data: parameterized DW-wide 2:1 combinational mux (sel, d0, d1 -> y), instantiated once.
//  Top holds the arbitration FSM, last_grant and the output register.
// TESTING
//  1 Reset: rst_n=0, then 1 -> out_valid=0, out_data=0, out_sel=0, a_ready=b_ready=0 with no valids.
//  2 Single: a_valid=1, a_data=8'h3C, out_ready=1 -> a_ready=1; next cycle out_valid=1, out_data=3C, out_sel=0.
//  3 Round robin: a_valid=b_valid=1 for 4 cycles, data A=11, B=22, out_ready=1
//    -> out_data sequence 11,22,11,22 and out_sel 0,1,0,1.
//  4 Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> a_ready=b_ready=0;
//    out_data is unchanged; resumes when out_ready=1.
//  5 Lock (ARB_LOCK_EN): A sends 3 beats with last on the 3rd while b_valid=1 throughout
//    -> out_sel 0,0,0 then 1. Without ARB_LOCK_EN -> out_sel 0,1,0,1.
//  6 Reset mid-burst: assert rst_n=0 while in LOCK_A with out_valid=1
//    -> out_valid=0 immediately; after release, a contested request is granted to A from IDLE.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared state encoding and select constants for mux2_rr_arbiter
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_data.sv
// rtl/mux2_data.sv - DW-wide combinational 2:1 data mux
module mux2_data #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  output logic [DW-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin 2:1 arbiter feeding a one-deep output register
// Optional burst locking is built when ARB_LOCK_EN is defined.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  input  logic          a_last,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  input  logic          b_last,
  output logic          b_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sel,
  input  logic          out_ready
);

  arb_state_e    state_q, state_d;
  logic          last_grant_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_sel_q;

  logic          can_load;
  logic          gnt_valid;
  logic          gnt_sel;
  logic          accept;
  logic [DW-1:0] mux_y;

  assign can_load = !out_valid_q || out_ready;

  mux2_data #(.DW(DW)) u_mux (
    .sel (gnt_sel),
    .d0  (a_data),
    .d1  (b_data),
    .y   (mux_y)
  );

  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = SEL_A;
    state_d   = state_q;

    case (state_q)
`ifdef ARB_LOCK_EN
      ST_LOCK_A: begin
        gnt_valid = 1'b1;
        gnt_sel   = SEL_A;
      end
      ST_LOCK_B: begin
        gnt_valid = 1'b1;
        gnt_sel   = SEL_B;
      end
`endif
      default: begin
        // Contested requests go to whoever did not win last time.
        if (a_valid && b_valid) begin
          gnt_valid = 1'b1;
          gnt_sel   = ~last_grant_q;
        end else if (a_valid) begin
          gnt_valid = 1'b1;
          gnt_sel   = SEL_A;
        end else if (b_valid) begin
          gnt_valid = 1'b1;
          gnt_sel   = SEL_B;
        end
      end
    endcase

    a_ready = gnt_valid && (gnt_sel == SEL_A) && can_load;
    b_ready = gnt_valid && (gnt_sel == SEL_B) && can_load;
    accept  = (a_valid && a_ready) || (b_valid && b_ready);

`ifdef ARB_LOCK_EN
    if (accept) begin
      if ((gnt_sel == SEL_B) ? b_last : a_last) begin
        state_d = ST_IDLE;
      end else begin
        state_d = (gnt_sel == SEL_B) ? ST_LOCK_B : ST_LOCK_A;
      end
    end
`else
    state_d = ST_IDLE;
`endif
  end

`ifndef ARB_LOCK_EN
  logic unused_last;
  assign unused_last = a_last ^ b_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SEL_B;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= SEL_A;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= mux_y;
        out_sel_q    <= gnt_sel;
        last_grant_q <= gnt_sel;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed self-checking bench for mux2_rr_arbiter
// Expectations follow ARB_LOCK_EN when it is defined for the build.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, a_last, b_last, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, out_valid, out_sel;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    a_data = 8'h00; b_data = 8'h00; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [7:0] rr_data [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
  logic       rr_sel  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef ARB_LOCK_EN
  logic       lk_sel  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
  logic       lk_sel  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    rst_n = 1'b1;
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);

    // Single beat from A
    a_valid = 1'b1; a_data = 8'h3C; out_ready = 1'b1;
    #1;
    check("single_a_ready", a_ready, 1);
    check("single_b_ready", b_ready, 0);
    @(negedge clk);
    a_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 8'h3C);
    check("single_sel", out_sel, 0);
    @(negedge clk);
    check("single_drain", out_valid, 0);

    // Round robin with both requesters continuously valid
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr_valid%0d", i), out_valid, 1);
      check($sformatf("rr_data%0d", i), out_data, rr_data[i]);
      check($sformatf("rr_sel%0d", i), out_sel, rr_sel[i]);
    end

    // Backpressure holds the beat and blocks both requesters
    b_valid = 1'b0; a_data = 8'h55; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_a_ready%0d", i), a_ready, 0);
      check($sformatf("bp_b_ready%0d", i), b_ready, 0);
      @(negedge clk);
      check($sformatf("bp_valid%0d", i), out_valid, 1);
      check($sformatf("bp_data%0d", i), out_data, 8'h22);
      check($sformatf("bp_sel%0d", i), out_sel, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    check("bp_resume_data", out_data, 8'h55);
    check("bp_resume_sel", out_sel, 0);
    @(negedge clk);
    check("bp_drain", out_valid, 0);

    // Burst lock: A has last on its third beat, B valid throughout
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA1; b_data = 8'hB1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_last = (i == 2);
      @(negedge clk);
      check($sformatf("lock_sel%0d", i), out_sel, lk_sel[i]);
      check($sformatf("lock_data%0d", i), out_data, lk_sel[i] ? 8'hB1 : 8'hA1);
    end

    // Reset while a beat is held mid-burst
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_last = 1'b0; b_last = 1'b0;
    a_data = 8'h66; b_data = 8'h77; out_ready = 1'b0;
    @(negedge clk);
    check("mid_held", out_valid, 1);
    check("mid_sel", out_sel, 0);
    rst_n = 1'b0;
    #1;
    check("mid_async_clear", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_a_ready", a_ready, 1);
    check("mid_b_ready", b_ready, 0);
    @(negedge clk);
    check("mid_after_sel", out_sel, 0);
    check("mid_after_data", out_data, 8'h66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
